// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Polarity constants mirror the existing codebase so the PC register and this block agree.
package instr_fetch_unit_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic RESET_EN = 1'b0;
    localparam logic HOLD     = 1'b1;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // Internal occupancy snapshot, exported so checkers can watch credit and drop accounting.
    typedef struct packed {
        logic [7:0] outst_cnt;
        logic [7:0] drop_cnt;
        logic [7:0] fifo_cnt;
    } ifu_dbg_t;

    // Sequential pc; wraps naturally modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] a);
        return a + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with a synchronous clear and an occupancy count.
// Head data is presented combinationally; push when full and pop when empty are ignored.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Clear shares the reset path: pointers and count collapse, stored words become don't-care.
    always_ff @(posedge clk) begin
        if (rstn == RESET_EN || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage controller: drives next_pc/hold to the PC register, issues imem fetches,
// tags in-order responses with their pc and buffers them for decode; flushes on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               hold,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output ifu_dbg_t           dbg
);

    // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge.
    // valid never depends on ready; imem responses have no backpressure and arrive in order.

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTST + 1);
    localparam int DCW = 8;

    logic [OCW-1:0]    outst_cnt;
    logic [FCW-1:0]    fifo_cnt;
    logic [DCW-1:0]    drop_cnt;
    logic [ADDR_W-1:0] tag_head;
    logic [7:0]        used;
    logic              credit_ok;
    logic              req_fire;
    logic              rsp_keep;
    logic              rsp_drop;
    logic              instr_pop;

    // The tag queue holds one pc per live (non-dropped) request, so its count is outst_cnt.
    assign used      = 8'(outst_cnt) + 8'(fifo_cnt);
    assign credit_ok = (used < 8'(DEPTH)) && (outst_cnt < OCW'(MAX_OUTST));

    assign imem_req_valid = credit_ok && !redirect_valid && (rstn != RESET_EN);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign hold    = (!redirect_valid && !req_fire) ? HOLD : ~HOLD;
    assign next_pc = redirect_valid ? redirect_pc : pc_incr(pc);

    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign instr_valid = (fifo_cnt != '0);
    assign instr_pop   = instr_valid && instr_ready;

    // Every request still in memory becomes stale on redirect; a response arriving in
    // the redirect cycle itself retires one of them immediately.
    always_ff @(posedge clk) begin
        if (rstn == RESET_EN) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= drop_cnt + DCW'(outst_cnt) - DCW'(imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_cnt <= drop_cnt - DCW'(1);
        end
    end

    fetch_fifo #(
        .W     (ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_q (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_keep),
        .head      (tag_head),
        .count     (outst_cnt)
    );

    fetch_fifo #(
        .W     (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({tag_head, imem_rsp_data}),
        .pop       (instr_pop),
        .head      ({instr_pc, instr}),
        .count     (fifo_cnt)
    );

    assign dbg = '{outst_cnt: 8'(outst_cnt), drop_cnt: drop_cnt, fifo_cnt: 8'(fifo_cnt)};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC-register model, a latency-programmable
// in-order memory model and an expected-instruction queue checked at every decode pop.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        hold;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    ifu_dbg_t    dbg;

    instr_fetch_unit #(.DEPTH(4), .MAX_OUTST(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc             (pc),
        .next_pc        (next_pc),
        .hold           (hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .dbg            (dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / models ----------------
    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] pop_log[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mem_lat     = 0;
    int pops        = 0;
    int hold_cnt    = 0;

    logic [31:0] s_pc, s_next;
    logic        s_hold, s_req_valid, s_fire, s_pop, s_rsp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Inputs set by the caller
    // beforehand apply to this cycle; the PC register model updates after the rising edge.
    task automatic cycle();
        logic [63:0] e;
        if (!rstn) mem_q.delete();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        s_pc        = pc;
        s_next      = next_pc;
        s_hold      = hold;
        s_req_valid = imem_req_valid;
        s_fire      = imem_req_valid && imem_req_ready;
        s_pop       = instr_valid && instr_ready;
        s_rsp       = imem_rsp_valid;
        if (s_hold == HOLD) hold_cnt++;
        if (s_pop) begin
            pops++;
            pop_log.push_back(instr_pc);
            chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", {instr_pc, instr}, e);
            end
        end
        if (s_fire) begin
            chk("req_addr", 64'(imem_req_addr), 64'(pc));
            mem_q.push_back('{due: cyc + 1 + mem_lat, addr: pc});
            exp_q.push_back({pc, mem_word(pc)});
        end
        if (redirect_valid || !rstn) exp_q.delete();
        @(posedge clk);
        #1;
        if (!rstn) pc = PC_RST;
        else if (s_hold != HOLD) pc = s_next;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic ok;
        rstn           = 1'b0;
        pc             = PC_RST;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b1;
        @(negedge clk);

        // Reset
        cycle();
        chk("rst_req_valid", 64'(s_req_valid), 64'd0);
        cycle();
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        rstn = 1'b1;
        chk("post_rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("post_rst_dbg", 64'(dbg), 64'd0);

        // T1: zero-wait memory, decode always ready
        pop_log.delete(); pops = 0; hold_cnt = 0;
        repeat (10) cycle();
        chk("t1_pops", 64'(pops), 64'd8);
        chk("t1_hold_cnt", 64'(hold_cnt), 64'd0);
        chk("t1_pc0", 64'(pop_log[0]), 64'h100);
        chk("t1_pc1", 64'(pop_log[1]), 64'h104);
        chk("t1_pc2", 64'(pop_log[2]), 64'h108);

        // T2: decode stalls until the FIFO is full, then resumes
        instr_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_fifo_cnt", 64'(dbg.fifo_cnt), 64'd4);
        chk("t2_outst_cnt", 64'(dbg.outst_cnt), 64'd0);
        chk("t2_instr_valid", 64'(instr_valid), 64'd1);
        chk("t2_hold", 64'(s_hold), 64'(HOLD));
        chk("t2_req_valid", 64'(s_req_valid), 64'd0);
        instr_ready = 1'b1;
        pops = 0;
        repeat (12) cycle();
        chk("t2_resume_pops", 64'(pops), 64'd12);

        // T3: memory refuses requests for 3 cycles
        begin
            logic [31:0] p0;
            p0 = pc;
            imem_req_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cycle();
                chk("t3_hold", 64'(s_hold), 64'(HOLD));
                chk("t3_pc_stable", 64'(s_pc), 64'(p0));
                chk("t3_next_pc", 64'(s_next), 64'(p0 + 32'd4));
                chk("t3_no_fire", 64'(s_fire), 64'd0);
            end
            chk("t3_pc_after", 64'(pc), 64'(p0));
            imem_req_ready = 1'b1;
            repeat (4) cycle();
        end

        // T4: redirect with two requests in flight
        mem_lat = 3;
        for (int i = 0; i < 12; i++) begin
            if (dbg.outst_cnt == 8'd2) break;
            cycle();
        end
        chk("t4_two_in_flight", 64'(dbg.outst_cnt), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        chk("t4_instr_valid", 64'(instr_valid), 64'd0);
        chk("t4_fifo_cnt", 64'(dbg.fifo_cnt), 64'd0);
        chk("t4_outst_cnt", 64'(dbg.outst_cnt), 64'd0);
        chk("t4_drop_cnt", 64'(dbg.drop_cnt), 64'(2 - int'(s_rsp)));
        pop_log.delete();
        repeat (14) cycle();
        chk("t4_first_pc", 64'(pop_log[0]), 64'h200);
        chk("t4_second_pc", 64'(pop_log[1]), 64'h204);

        // T5: redirect coinciding with a response and a decode pop
        mem_lat = 0;
        repeat (10) cycle();
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ok = instr_valid && mem_q.size() > 0 && mem_q[0].due <= cyc;
            if (ok) break;
            cycle();
        end
        chk("t5_setup", 64'(ok), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        chk("t5_rsp_seen", 64'(s_rsp), 64'd1);
        chk("t5_pop_seen", 64'(s_pop), 64'd1);
        chk("t5_instr_valid", 64'(instr_valid), 64'd0);
        chk("t5_fifo_cnt", 64'(dbg.fifo_cnt), 64'd0);
        chk("t5_drop_cnt", 64'(dbg.drop_cnt), 64'd0);
        pop_log.delete();
        repeat (8) cycle();
        chk("t5_first_pc", 64'(pop_log[0]), 64'h300);

        // T6: pc wrap, then reset in the middle of a stream
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        pop_log.delete();
        cycle();
        chk("t6_pc", 64'(s_pc), 64'hFFFF_FFFC);
        chk("t6_next_pc_wrap", 64'(s_next), 64'h0);
        chk("t6_fire", 64'(s_fire), 64'd1);
        repeat (6) cycle();
        chk("t6_pop0", 64'(pop_log[0]), 64'hFFFF_FFFC);
        chk("t6_pop1", 64'(pop_log[1]), 64'h0);
        chk("t6_pop2", 64'(pop_log[2]), 64'h4);

        mem_lat = 2;
        repeat (3) cycle();
        rstn = 1'b0;
        cycle();
        chk("t6_rst_req_valid", 64'(s_req_valid), 64'd0);
        rstn = 1'b1;
        chk("t6_rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("t6_rst_dbg", 64'(dbg), 64'd0);
        mem_lat = 0;
        pop_log.delete();
        repeat (8) cycle();
        chk("t6_restart_pc", 64'(pop_log[0]), 64'h100);

        // Drain: stop fetching, everything requested must reach decode exactly once
        imem_req_ready = 1'b0;
        repeat (10) cycle();
        chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_instr_valid", 64'(instr_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
